// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Purpose  : Sequential DES/3DES round-key generator. Holds NUM_KEYS key
//            slots (stored already PC-1 permuted, so parity bits are dropped
//            at load time). It emits the 16 48-bit subkeys in encrypt order
//            (K1..K16) or decrypt order (K16..K1) over a valid/ready
//            handshake, rotating C/D on the fly.
//            Bit convention: vector bit i is FIPS bit i+1.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule #(
  parameter int NUM_KEYS = 3,
  parameter int SEL_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             key_load,
  input  logic [SEL_W-1:0] key_sel,
  input  logic [63:0]      key_in,
  input  logic             start,
  input  logic             decrypt,
  output logic [47:0]      subkey,
  output logic             subkey_valid,
  input  logic             subkey_ready,
  output logic [3:0]       round_num,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  // PC-1 and PC-2 selection tables, FIPS 1-based source positions
  localparam int c_pc1_tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int c_pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] cd;
    logic [5:0]  idx;
    cd = '0;
    for (int i = 0; i < 56; i++) begin
      idx   = 6'(c_pc1_tab[i] - 1);
      cd[i] = k[idx];
    end
    return cd;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] ks;
    logic [5:0]  idx;
    ks = '0;
    for (int i = 0; i < 48; i++) begin
      idx   = 6'(c_pc2_tab[i] - 1);
      ks[i] = cd[idx];
    end
    return ks;
  endfunction

  // C is cd[27:0], D is cd[55:28]; a FIPS left rotate moves bits toward
  // lower vector index inside each half.
  function automatic logic [55:0] f_rot(input logic [55:0] cd,
                                        input logic        left,
                                        input logic        two);
    logic [27:0] c;
    logic [27:0] d;
    c = cd[27:0];
    d = cd[55:28];
    if (left) begin
      if (two) begin
        c = {c[1:0], c[27:2]};
        d = {d[1:0], d[27:2]};
      end else begin
        c = {c[0], c[27:1]};
        d = {d[0], d[27:1]};
      end
    end else begin
      if (two) begin
        c = {c[25:0], c[27:26]};
        d = {d[25:0], d[27:26]};
      end else begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
    end
    return {d, c};
  endfunction

  // Rounds 1, 2, 9 and 16 (round_num 0, 1, 8, 15) shift by one, all others by two
  function automatic logic f_shift2(input logic [3:0] r);
    return !((r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15));
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [55:0] r_slot [NUM_KEYS];
  logic [55:0] r_cd;
  logic [3:0]  r_round;
  logic        r_mode;
  logic        r_done;

  logic        w_sel_ok;
  logic [55:0] w_slot_cd;
  logic        w_last;
  logic        w_launch;
  logic        w_advance;
  logic        w_finish;
  logic [3:0]  w_round_inc;
  logic        w_unused_parity;

  // Parity bits are never used; slots keep only the PC-1 image
  assign w_unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                             key_in[39], key_in[47], key_in[55], key_in[63]};

  assign w_sel_ok    = ({1'b0, key_sel} < (SEL_W + 1)'(NUM_KEYS));
  assign w_last      = r_mode ? (r_round == 4'd0) : (r_round == 4'd15);
  assign w_round_inc = r_round + 4'd1;

  // Select the addressed slot; out-of-range selects read as zero
  always_comb begin
    w_slot_cd = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_sel == SEL_W'(i)) begin
        w_slot_cd = r_slot[i];
      end
    end
  end

  // Key bank: load permuted key into the addressed slot, cleared by reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_slot[i] <= '0;
      end
    end else if (key_load) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_sel == SEL_W'(i)) begin
          r_slot[i] <= f_pc1(key_in);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_advance = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && w_sel_ok) begin
          w_next   = S_PRESENT;
          w_launch = 1'b1;
        end
      end
      S_PRESENT: begin
        if (subkey_ready) begin
          if (w_last) begin
            w_next   = S_IDLE;
            w_finish = 1'b1;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // C/D rotation, round counter, mode latch and done pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cd    <= '0;
      r_round <= 4'd0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_launch) begin
        r_mode  <= decrypt;
        r_round <= decrypt ? 4'd15 : 4'd0;
        // C0D0 equals C16D16, so decrypt starts from the unrotated image
        r_cd    <= decrypt ? w_slot_cd : f_rot(w_slot_cd, 1'b1, 1'b0);
      end else if (w_advance) begin
        if (!r_mode) begin
          r_round <= w_round_inc;
          r_cd    <= f_rot(r_cd, 1'b1, f_shift2(w_round_inc));
        end else begin
          r_round <= r_round - 4'd1;
          r_cd    <= f_rot(r_cd, 1'b0, f_shift2(r_round));
        end
      end
    end
  end

  assign subkey       = f_pc2(r_cd);
  assign subkey_valid = (r_state == S_PRESENT);
  assign busy         = (r_state == S_PRESENT);
  assign round_num    = r_round;
  assign done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Purpose  : Self-checking bench for des_key_schedule. A software-style
//            (MSB-first) key schedule model fills a scoreboard queue when a
//            schedule is started; a negedge monitor pops and compares on
//            every accepted subkey.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

  localparam int NUM_KEYS = 3;
  localparam int SEL_W    = 2;
  localparam logic [63:0] c_par_mask = 64'h8080_8080_8080_8080;

  typedef struct packed {
    logic [47:0] sk;
    logic [3:0]  rn;
  } ent_t;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             key_load = 1'b0;
  logic [SEL_W-1:0] key_sel = '0;
  logic [63:0]      key_in = '0;
  logic             start = 1'b0;
  logic             decrypt = 1'b0;
  logic             subkey_ready = 1'b1;
  logic [47:0]      subkey;
  logic             subkey_valid;
  logic [3:0]       round_num;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int vcyc_cnt = 0;
  int done_cnt = 0;

  ent_t sbq [$];
  ent_t cap [$];
  ent_t cap_e [$];
  ent_t e;
  logic [47:0] mks [16];

  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [47:0] prev_sk = '0;
  logic [3:0]  prev_rn = '0;
  logic        exp_done = 1'b0;

  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule #(.NUM_KEYS(NUM_KEYS)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .key_load    (key_load),
    .key_sel     (key_sel),
    .key_in      (key_in),
    .start       (start),
    .decrypt     (decrypt),
    .subkey      (subkey),
    .subkey_valid(subkey_valid),
    .subkey_ready(subkey_ready),
    .round_num   (round_num),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[63-i];
    return y;
  endfunction

  function automatic logic [47:0] rev48(input logic [47:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[i] = x[47-i];
    return y;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
      $error("check %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Classic MSB-first model: FIPS bit 1 is the MSB, results bit-reversed
  // into the vector convention at the end.
  task automatic compute_model(input logic [63:0] kvec);
    logic [63:0] k;
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] ks;
    k = rev64(kvec);
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < sh_t[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) ks[47-j] = cd[56-pc2_t[j]];
      mks[r] = rev48(ks);
    end
  endtask

  task automatic push_model(input logic [63:0] kvec, input bit dec);
    int r;
    compute_model(kvec);
    for (int i = 0; i < 16; i++) begin
      r = dec ? 15 - i : i;
      sbq.push_back({mks[r], 4'(r)});
    end
  endtask

  task automatic load(input int sel, input logic [63:0] k);
    @(posedge clk); #1;
    key_load = 1'b1;
    key_sel  = SEL_W'(sel);
    key_in   = k;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  // One schedule: start, drive ready, optional illegal start pokes and a
  // mid-run slot load, then wait (bounded) for done.
  task automatic run(input int sel, input bit dec, input logic [63:0] mk,
                     input bit rnd, input bit poke, input bit load_mid,
                     input logic [63:0] mid_key);
    int k;
    int d0;
    int a0;
    int v0;
    push_model(mk, dec);
    cap.delete();
    a0 = acc_cnt;
    v0 = vcyc_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    key_sel      = SEL_W'(sel);
    decrypt      = dec;
    start        = 1'b1;
    subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(negedge clk);
    chk("valid_before_edge", {63'd0, subkey_valid}, 64'd0);
    k = 0;
    while (done_cnt == d0 && k < 400) begin
      @(posedge clk); #1;
      k++;
      start    = 1'b0;
      key_load = 1'b0;
      if (rnd) subkey_ready = 1'($urandom_range(0, 1));
      if (poke && (k == 5 || k == 16)) begin
        start   = 1'b1;
        key_sel = SEL_W'(1);
        decrypt = ~dec;
      end
      if (load_mid && k == 3) begin
        key_load = 1'b1;
        key_sel  = SEL_W'(0);
        key_in   = mid_key;
      end
      @(negedge clk);
      if (k == 1) chk("valid_latency", {63'd0, subkey_valid}, 64'd1);
    end
    if (done_cnt == d0) begin
      errors++;
      checks++;
      $display("FAIL timeout: observed=no done expected=done within 400 cycles");
    end
    start        = 1'b0;
    key_load     = 1'b0;
    subkey_ready = 1'b1;
    chk("idle_after_done", {62'd0, busy, subkey_valid}, 64'd0);
    chk("accept_count", 64'(acc_cnt - a0), 64'd16);
    if (!rnd) chk("valid_cycles", 64'(vcyc_cnt - v0), 64'd16);
  endtask

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_v   = 1'b0;
      prev_r   = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (done || exp_done) chk("done_pulse", {63'd0, done}, {63'd0, exp_done});
      if (done) done_cnt++;
      if (prev_v && !prev_r)
        chk("hold", {11'd0, subkey_valid, subkey, round_num}, {11'd0, 1'b1, prev_sk, prev_rn});
      if (subkey_valid) vcyc_cnt++;
      exp_done = 1'b0;
      if (subkey_valid && subkey_ready) begin
        acc_cnt++;
        cap.push_back({subkey, round_num});
        if (sbq.size() == 0) begin
          chk("unexpected_subkey", {12'd0, subkey, round_num}, 64'd0 - 64'd1);
        end else begin
          e = sbq.pop_front();
          chk("subkey_round", {12'd0, subkey, round_num}, {12'd0, e.sk, e.rn});
          exp_done = (sbq.size() == 0);
        end
      end
      prev_v  = subkey_valid;
      prev_r  = subkey_ready;
      prev_sk = subkey;
      prev_rn = round_num;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] k0;
    logic [63:0] k1;
    logic [63:0] k2;
    k0 = rev64(64'h1334_5779_9BBC_DFF1);
    k1 = {$urandom, $urandom};
    k2 = {$urandom, $urandom};

    // Power-on reset state
    #12;
    chk("rst_subkey", {16'd0, subkey}, 64'd0);
    chk("rst_flags", {61'd0, subkey_valid, busy, done}, 64'd0);
    chk("rst_round", {60'd0, round_num}, 64'd0);
    #5 n_rst = 1'b1;

    // Encrypt FIPS key with illegal starts while busy and at the last accept
    load(0, k0);
    run(0, 1'b0, k0, 1'b0, 1'b1, 1'b0, 64'd0);
    cap_e = cap;
    chk("k1_value", {16'd0, cap_e[0].sk}, {16'd0, rev48(48'h1B02EFFC7072)});
    chk("k1_round", {60'd0, cap_e[0].rn}, 64'd0);
    chk("k16_value", {16'd0, cap_e[15].sk}, {16'd0, rev48(48'hCB3D8B0E17F5)});
    chk("k16_round", {60'd0, cap_e[15].rn}, 64'd15);

    // Decrypt same key: exact reverse of encrypt
    run(0, 1'b1, k0, 1'b0, 1'b0, 1'b0, 64'd0);
    chk("dec_first", {12'd0, cap[0]}, {12'd0, rev48(48'hCB3D8B0E17F5), 4'd15});
    chk("dec_last", {12'd0, cap[15]}, {12'd0, rev48(48'h1B02EFFC7072), 4'd0});
    for (int i = 0; i < 16; i++) chk("dec_reverse", {12'd0, cap[i]}, {12'd0, cap_e[15-i]});

    // Backpressure
    run(0, 1'b0, k0, 1'b1, 1'b0, 1'b0, 64'd0);

    // Multi-slot, mid-run load, parity insensitivity
    load(1, k1);
    load(2, k2);
    run(0, 1'b0, k0, 1'b0, 1'b0, 1'b1, k0 ^ c_par_mask);
    run(1, 1'b1, k1, 1'b1, 1'b0, 1'b0, 64'd0);
    run(2, 1'b0, k2, 1'b0, 1'b0, 1'b0, 64'd0);
    run(0, 1'b0, k0, 1'b0, 1'b0, 1'b0, 64'd0);

    // Out-of-range slot: load and start ignored
    load(3, {$urandom, $urandom});
    @(posedge clk); #1;
    key_sel = 2'd3;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("illegal_busy", {62'd0, busy, subkey_valid}, 64'd0);
    end
    run(2, 1'b0, k2, 1'b0, 1'b0, 1'b0, 64'd0);

    // Asynchronous reset mid-schedule clears outputs and slots
    push_model(k0, 1'b0);
    @(posedge clk); #1;
    key_sel = 2'd0;
    decrypt = 1'b0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("arst_subkey", {16'd0, subkey}, 64'd0);
    chk("arst_flags", {61'd0, subkey_valid, busy, done}, 64'd0);
    chk("arst_round", {60'd0, round_num}, 64'd0);
    sbq.delete();
    @(posedge clk); #3;
    n_rst = 1'b1;
    run(0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0);

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES/3DES round-key generator with a bank of NUM_KEYS 64-bit key slots.
- On request it applies PC-1 to the selected key, then produces 16 48-bit subkeys in encrypt order (K1..K16) or decrypt order (K16..K1). Subkeys are generated with on-the-fly C/D rotation and PC-2.
- Subkeys are handed to the round datapath through a valid/ready handshake.
- Sits between the I2C register interface (key loading) and the Triple-DES round engine.

Parameters:
- NUM_KEYS, 3, number of key slots (3 for keying option 1 of 3DES); must be >= 1.
- SEL_W, $clog2(NUM_KEYS) (min 1), width of key_sel.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- key_load  in  1  write key_in into slot key_sel this cycle
- key_sel  in  SEL_W  slot index for load and start
- key_in  in  64  raw key incl. parity bits
- start  in  1  begin a schedule from slot key_sel
- decrypt  in  1  sampled with start; 1 = emit K16..K1
- subkey  out  48  current round subkey
- subkey_valid  out  1  subkey/round_num valid
- subkey_ready  in  1  consumer accepts when high with subkey_valid
- round_num  out  4  FIPS round number minus 1 (0 = K1, 15 = K16)
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after last subkey accepted

Behaviour:
- Bit convention: vector bit i = FIPS 46-3 bit i+1. key_in[0] is the leftmost key bit; subkey[0] is the leftmost subkey bit. Parity bits key_in[7,15,...,63] are ignored.
- PC-1 is per FIPS: CD[0] = key[56], CD[1] = key[48], ..., CD[55] = key[3]. C = CD[0:27], D = CD[28:55]. The FIPS "rotate left" moves bits toward lower index within each 28-bit half.
- Shift schedule for rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- subkey = PC-2(CD register), purely combinational from registered CD, so it is stable while valid.
- Reset state: all slots 0, CD 0, state IDLE. Outputs: subkey 0, subkey_valid 0, round_num 0, busy 0, done 0.
- key_load: when key_sel < NUM_KEYS, the slot updates on the next edge. It is allowed while busy and does not affect the schedule in progress, because CD has already been captured. Out-of-range key_sel makes the load a no-op.
- FSM has two states, IDLE and PRESENT.
- IDLE to PRESENT: on start with key_sel < NUM_KEYS. Then:
  - CD <= PC-1(slot) rotated left 1 if encrypt, unrotated if decrypt (C0D0 equals C16D16).
  - mode latched from decrypt.
  - round_num <= 0 (encrypt) or 15 (decrypt).
  - busy and subkey_valid go high the cycle after start (latency 1).
- IDLE, other cases: start with out-of-range key_sel is ignored.
- PRESENT, no handshake: subkey, round_num and CD hold while subkey_valid && !subkey_ready.
- PRESENT, on accept (valid && ready), not last round:
  - Encrypt: round_num+1; CD rotated left by shift[new round].
  - Decrypt: CD rotated right by shift[current round]; round_num-1.
  - With ready held high, one subkey is produced per cycle: 16 consecutive valid cycles.
- PRESENT, on accept of the last subkey (round 15 encrypt, round 0 decrypt):
  - Go to IDLE; subkey_valid and busy drop next cycle.
  - done pulses high for exactly that one cycle.
- start while busy is ignored, including in the accept-last cycle.
- Reset asserted mid-schedule returns immediately to the reset state. The key slots are cleared too.

Test Plan:
- Reset: drive n_rst low mid-schedule, asynchronously -> all outputs 0 before the next clk edge. Slot 0 reads back as 0: a subsequent start yields PC-2(0) = 0 subkeys.
- Encrypt, key slot 0 = FIPS 133457799BBCDFF1, ready held high -> valid for 16 consecutive cycles starting 1 cycle after start.
  - FIPS-order K1 = 1B02EFFC7072, round_num 0.
  - FIPS-order K16 = CB3D8B0E17F5, round_num 15.
  - done pulses the cycle after the K16 accept.
- Decrypt, same key -> first subkey CB3D8B0E17F5 with round_num 15; last subkey 1B02EFFC7072 with round_num 0. The full sequence is the exact reverse of the encrypt capture.
- Backpressure: toggle subkey_ready randomly -> subkey and round_num stable while unaccepted; no round is skipped or repeated; 16 accepts total.
- Multi-slot: load slots 0/1/2 with different keys, run E(k0), D(k1), E(k2) back-to-back -> each sequence matches the golden model.
  - A load to slot 0 during the k0 run does not alter that run.
  - Flipping only parity bits gives identical subkeys.
- Illegal requests:
  - start while busy -> ignored; sequence unaffected.
  - key_sel = 3 with NUM_KEYS = 3 -> load and start ignored; busy stays 0.
